// File: rtl/inst_trace_buffer.sv
// Retired-instruction trace FIFO (first-word-fall-through) with sequence stamping and drop accounting.
// Optional macro TRACE_NOP_FILTER_EN discards canonical NOPs and bubbles before they reach the FIFO.
module inst_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_imm,
    input  logic [31:0]              in_pc,
    input  logic                     flush,
    input  logic                     clr_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_imm,
    output logic [31:0]              out_pc,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [SEQ_W-1:0]         drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]      inst;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [SEQ_W-1:0] seq;
    logic             is_nop;
    logic             qual;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

`ifdef TRACE_NOP_FILTER_EN
    assign is_nop = (in_inst == 32'h0000_0013) || (in_inst == 32'h0000_0000);
`else
    assign is_nop = 1'b0;
`endif

    assign qual = in_valid && !is_nop;
    assign full = (count == (AW+1)'(DEPTH));
    assign pop  = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = qual && (!full || pop);
    assign drop = qual && !push;

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_inst  = head.inst;
    assign out_imm   = head.imm;
    assign out_pc    = head.pc;
    assign out_seq   = head.seq;

    // Storage carries no reset; only the pointers give it meaning.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr] <= '{inst: in_inst, imm: in_imm, pc: in_pc, seq: seq};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            seq      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            // Every qualifying entry consumes a number, so drops and flushes show as gaps.
            if (qual) seq <= seq + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (clr_ovf)        drop_cnt <= SEQ_W'(1);
                else if (!(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_inst_trace_buffer.sv
// Bench for inst_trace_buffer: directed scenarios then random traffic against a queue-based model.
module tb_inst_trace_buffer;
    localparam int DEPTH = 8;
    localparam int SEQ_W = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD = 32'h0020_81B3;

    logic clk, rst, in_valid, flush, clr_ovf, out_ready;
    logic [31:0] in_inst, in_imm, in_pc;
    logic out_valid, overflow;
    logic [31:0] out_inst, out_imm, out_pc;
    logic [SEQ_W-1:0] out_seq, drop_cnt;
    logic [$clog2(DEPTH):0] count;

    inst_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_imm(in_imm),
        .in_pc(in_pc), .flush(flush), .clr_ovf(clr_ovf), .out_ready(out_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_imm(out_imm), .out_pc(out_pc),
        .out_seq(out_seq), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      inst;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [SEQ_W-1:0] seq;
    } ent_t;

    ent_t        q[$];
    int unsigned mseq;
    bit          movf;
    int unsigned mdcnt;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit filtered(input logic [31:0] inst);
`ifdef TRACE_NOP_FILTER_EN
        return (inst == NOP) || (inst == 32'h0);
`else
        return (inst == NOP) && (inst != NOP);
`endif
    endfunction

    // Reference: apply the cycle's inputs to the queue view of the buffer.
    task automatic model_edge();
        bit qual, pop, full, drop;
        if (rst) begin
            q.delete();
            mseq = 0; movf = 0; mdcnt = 0;
            return;
        end
        qual = in_valid && !filtered(in_inst);
        pop  = (q.size() != 0) && out_ready;
        full = (q.size() == DEPTH);
        drop = qual && full && !pop;
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (qual && !drop) q.push_back('{in_inst, in_imm, in_pc, mseq[SEQ_W-1:0]});
        end
        if (qual) mseq = (mseq + 1) % (1 << SEQ_W);
        if (clr_ovf) begin movf = 0; mdcnt = 0; end
        if (drop) begin
            movf = 1;
            if (mdcnt < (1 << SEQ_W) - 1) mdcnt++;
        end
    endtask

    task automatic check_model();
        chk("count", count, q.size());
        chk("out_valid", out_valid, q.size() != 0);
        chk("overflow", overflow, movf);
        chk("drop_cnt", drop_cnt, mdcnt);
        if (q.size() != 0) begin
            chk("head_inst", out_inst, q[0].inst);
            chk("head_imm", out_imm, q[0].imm);
            chk("head_pc", out_pc, q[0].pc);
            chk("head_seq", out_seq, q[0].seq);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set(input bit v, input logic [31:0] inst, input logic [31:0] pc, input bit rdy);
        in_valid = v; in_inst = inst; in_imm = $urandom; in_pc = pc; out_ready = rdy;
        flush = 0; clr_ovf = 0; rst = 0;
    endtask

    task automatic do_reset();
        set(0, 0, 0, 0);
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            set(1, ADD, base + 32'(i * 4), 0);
            step();
        end
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) begin
            set(0, 0, 0, 1);
            step();
        end
    endtask

    initial begin
        set(0, 0, 0, 0);
        rst = 1;
        step();
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dcnt", drop_cnt, 0);

        // Basic in-order push then drain.
        fill(3, 32'h0);
        set(0, 0, 0, 0);
        chk("b_count", count, 3);
        chk("b_pc", out_pc, 0);
        chk("b_seq", out_seq, 0);
        for (int i = 0; i < 3; i++) begin
            set(0, 0, 0, 1);
            step();
            if (i < 2) chk("b_popseq", out_seq, 64'(i + 1));
            else       chk("b_empty", out_valid, 0);
        end

        // Overflow, sequence gap, then reset overriding everything.
        do_reset();
        fill(8, 32'h100);
        set(1, ADD, 32'h200, 0);
        step();
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_dcnt", drop_cnt, 1);
        pops(7);
        set(1, ADD, 32'h300, 0);
        step();
        pops(1);
        chk("gap_seq", out_seq, 9);
        chk("gap_pc", out_pc, 32'h300);
        fill(3, 32'h400);
        chk("pre_rst_count", count, 4);
        chk("pre_rst_ovf", overflow, 1);
        set(1, ADD, 32'h4F0, 1);
        rst = 1; flush = 1; clr_ovf = 1;
        step();
        chk("r_count", count, 0);
        chk("r_ovf", overflow, 0);
        chk("r_dcnt", drop_cnt, 0);
        chk("r_valid", out_valid, 0);

        // Full with simultaneous push and pop.
        fill(8, 32'h500);
        set(1, ADD, 32'h5AA, 1);
        step();
        chk("fpp_count", count, 8);
        chk("fpp_ovf", overflow, 0);
        pops(7);
        chk("fpp_tail_pc", out_pc, 32'h5AA);
        chk("fpp_tail_seq", out_seq, 8);

        // Push and pop at count=1.
        do_reset();
        fill(1, 32'h700);
        set(1, ADD, 32'h710, 1);
        step();
        chk("one_count", count, 1);
        chk("one_pc", out_pc, 32'h710);

        // Flush with a concurrent push.
        do_reset();
        fill(5, 32'h600);
        set(1, ADD, 32'h6F0, 0);
        flush = 1;
        step();
        chk("fl_count", count, 0);
        chk("fl_valid", out_valid, 0);
        set(1, ADD, 32'h6F4, 0);
        step();
        chk("fl_seq", out_seq, 6);

        // NOP filter behaviour.
        do_reset();
        set(1, NOP, 32'h800, 0); step();
        set(1, 32'h0, 32'h804, 0); step();
        set(1, 32'h00A0_0093, 32'h808, 0); step();
`ifdef TRACE_NOP_FILTER_EN
        chk("nop_count", count, 1);
        chk("nop_inst", out_inst, 32'h00A0_0093);
        chk("nop_seq", out_seq, 0);
`else
        chk("nop_count", count, 3);
        chk("nop_inst", out_inst, NOP);
`endif

        // clr_ovf racing a drop.
        do_reset();
        fill(8, 32'h900);
        set(1, ADD, 32'h9F0, 0); step();
        set(1, ADD, 32'h9F4, 0); step();
        chk("clr_pre_dcnt", drop_cnt, 2);
        set(1, ADD, 32'h9F8, 0); clr_ovf = 1; step();
        chk("clr_race_ovf", overflow, 1);
        chk("clr_race_dcnt", drop_cnt, 1);
        set(0, 0, 0, 0); clr_ovf = 1; step();
        chk("clr_ovf", overflow, 0);
        chk("clr_dcnt", drop_cnt, 0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            logic [31:0] inst;
            r = $urandom_range(0, 3);
            inst = (r == 0) ? NOP : (r == 1) ? 32'h0 : 32'($urandom);
            set($urandom_range(0, 3) != 0, inst, 32'($urandom), $urandom_range(0, 2) == 0);
            flush   = ($urandom_range(0, 39) == 0);
            clr_ovf = ($urandom_range(0, 24) == 0);
            rst     = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inst_trace_buffer.md
INST_TRACE_BUFFER -- requirements
Module: inst_trace_buffer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of trace entries; legal values are powers of two from 2 to 64.
REQ-003 Parameter SEQ_W, default 16, SHALL set the width of the sequence and drop counters.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  a retiring instruction is presented this cycle.
REQ-007 in_inst  input  32  raw instruction word.
REQ-008 in_imm  input  32  decoded, sign-extended immediate.
REQ-009 in_pc  input  32  PC of the instruction.
REQ-010 flush  input  1  discards all stored entries.
REQ-011 clr_ovf  input  1  clears the overflow flag.
REQ-012 out_ready  input  1  the downstream decoder/printer accepts the head entry.
REQ-013 out_valid  output  1  the head entry is valid.
REQ-014 out_inst, out_imm, out_pc  output  32 each  fields of the head entry.
REQ-015 out_seq  output  SEQ_W  sequence number of the head entry.
REQ-016 count  output  log2(DEPTH)+1  number of stored entries.
REQ-017 overflow  output  1  sticky flag: at least one entry was dropped.
REQ-018 drop_cnt  output  SEQ_W  number of dropped entries; saturates at all-ones.

Function
REQ-019 Storage SHALL be a first-word-fall-through circular FIFO with read pointer, write pointer and count registers; pointers SHALL wrap modulo DEPTH.
REQ-020 Push: the entry SHALL be accepted when in_valid=1, the entry passes the filter (REQ-031) and either count<DEPTH or a pop occurs in the same cycle.
REQ-021 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-022 out_valid SHALL equal (count!=0); out_* SHALL show the entry at the read pointer, combinationally from storage.
REQ-023 Latency: an entry accepted at edge N SHALL be visible at out_* from edge N onward if the FIFO was empty, so it can pop in cycle N+1; no bypass from in_* to out_* in the same cycle.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, including when full and when count=1.
REQ-025 Each accepted entry SHALL be stamped with the current sequence counter, which SHALL then increment and wrap to 0 after all-ones.
REQ-026 A qualifying in_valid that is not accepted because the FIFO is full with no pop SHALL be dropped: overflow<=1 and drop_cnt increments unless saturated; the sequence counter SHALL also increment so gaps are visible.
REQ-027 flush SHALL set count, the read pointer and the write pointer to 0 at the next edge; any push or pop in that cycle SHALL be ignored; the sequence counter, overflow and drop_cnt SHALL be kept.
REQ-028 clr_ovf SHALL clear overflow and drop_cnt; a drop in the same cycle SHALL win, giving overflow=1 and drop_cnt=1.
REQ-029 When out_valid=0, out_* SHALL hold the last-read storage contents, which carry no meaning.

Reset
REQ-030 On rst=1 at a clock edge: count=0, both pointers=0, sequence counter=0, overflow=0, drop_cnt=0, out_valid=0; storage is not reset; rst SHALL override flush, clr_ovf and push.

Configuration
REQ-031 Macro TRACE_NOP_FILTER_EN SHALL control NOP filtering.
- Defined: in_valid entries with in_inst==32'h00000013 (canonical NOP) or in_inst==32'h00000000 (bubble) are silently discarded; they are not pushed, not counted as drops and do not increment the sequence counter.
- Not defined: every in_valid entry is handled per REQ-020 and REQ-026.

Verification
REQ-032 After reset, push 3 entries (pc 0x0, 0x4, 0x8; inst 0x002081B3) with out_ready=0 -> count=3, out_pc=0x0, out_seq=0; set out_ready=1 -> pops in order with seq 0,1,2, then out_valid=0.
REQ-033 Fill DEPTH=8 and push a 9th entry with out_ready=0 -> count=8, overflow=1, drop_cnt=1; the next accepted entry carries seq=9.
REQ-034 Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> count stays 8, overflow stays 0, new entry lands at the tail.
REQ-035 Load 5 entries, assert flush together with in_valid -> count=0 next cycle and out_valid=0; the next push gets seq=6.
REQ-036 With TRACE_NOP_FILTER_EN defined, push 0x00000013, 0x00000000, 0x00A00093 -> count=1, out_inst=0x00A00093, out_seq=0; without the macro -> count=3.
REQ-037 Assert rst with count=4 and overflow=1 -> next cycle count=0, overflow=0, drop_cnt=0, out_valid=0.
